// File: rtl/counter_chain_pkg.sv
// Shared types and helpers for the counter-chain accumulator.
//   cc_mode_e : output mode (per-beat sum or per-frame accumulate)
//   sum_w     : exact width of a0+a1+a2+a3+2*b for LENGTH-bit rows
//   sat_add   : w-bit saturating add, returns {ovf, result}
package counter_chain_pkg;

  typedef enum logic {
    CC_SUM = 1'b0,
    CC_ACC = 1'b1
  } cc_mode_e;

  // Four weight-1 rows plus one weight-2 row total at most 6*(2**L-1) < 2**(L+3).
  function automatic int unsigned sum_w(input int unsigned length);
    return length + 32'd3;
  endfunction

  // Operands are assumed to be below 2**w; w must be 1..63.
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] full;
    logic [63:0] mask;
    logic        ovf;
    full = {1'b0, a} + {1'b0, b};
    mask = (64'd1 << w) - 64'd1;
    ovf  = full[64] | ((full[63:0] & ~mask) != 64'd0);
    return {ovf, (ovf ? mask : (full[63:0] & mask))};
  endfunction

endpackage

// File: rtl/cc_sum_stage.sv
// Combinational counter-chain compressor.
// Reduces four weight-1 rows and one weight-2 row to their exact sum.
//   a0..a3 : LENGTH-bit weight-1 rows
//   b      : LENGTH-bit weight-2 row
//   sum    : LENGTH+3 bit exact sum a0+a1+a2+a3+2*b
// USETNM names the placement set the compressor cells belong to.
module cc_sum_stage
  import counter_chain_pkg::*;
#(
  parameter int unsigned LENGTH = 8,
  parameter string       USETNM = "USET0"
) (
  input  logic [LENGTH-1:0]         a0,
  input  logic [LENGTH-1:0]         a1,
  input  logic [LENGTH-1:0]         a2,
  input  logic [LENGTH-1:0]         a3,
  input  logic [LENGTH-1:0]         b,
  output logic [sum_w(LENGTH)-1:0]  sum
);

  localparam int unsigned SumW = sum_w(LENGTH);

  if (USETNM == "") begin : gen_bad_uset
    $error("cc_sum_stage: USETNM must name a placement set");
  end

  logic [SumW-1:0] x0, x1, x2, x3, xb;
  logic [SumW-1:0] s1, c1, s2, c2, s3, c3;

  // 3:2 counter; carry is already shifted to its weight. The carry MSB that falls
  // off can never be set because every partial sum is bounded by the exact total.
  function automatic logic [2*SumW-1:0] csa(input logic [SumW-1:0] x, input logic [SumW-1:0] y,
                                            input logic [SumW-1:0] z);
    logic [SumW-1:0] s, c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  always_comb begin
    x0 = SumW'(a0);
    x1 = SumW'(a1);
    x2 = SumW'(a2);
    x3 = SumW'(a3);
    xb = SumW'(b) << 1;
    {c1, s1} = csa(x0, x1, x2);
    {c2, s2} = csa(s1, x3, xb);
    {c3, s3} = csa(s2, c1, c2);
    sum = s3 + c3;
  end

endmodule

// File: rtl/counter_chain_acc.sv
// Streaming multi-operand accumulator.
// Each accepted beat sums a0..a3 (weight 1) and b (weight 2). In SUM mode every
// sum is forwarded; in ACC mode sums are accumulated until in_last and one total
// per frame is emitted.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : operand beat handshake, in_last closes a frame (ACC)
//   a0..a3, b            : operand rows
//   out_valid/out_ready  : result handshake
//   out_data             : zero-extended sum or frame total
//   out_ovf              : frame total overflowed ACC_W (ACC only)
module counter_chain_acc
  import counter_chain_pkg::*;
#(
  parameter int unsigned LENGTH = 8,
  parameter int unsigned ACC_W  = 24,
  parameter string       MODE   = "ACC",
  parameter string       SAT    = "FALSE",
  parameter string       USETNM = "USET0"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [LENGTH-1:0] a0,
  input  logic [LENGTH-1:0] a1,
  input  logic [LENGTH-1:0] a2,
  input  logic [LENGTH-1:0] a3,
  input  logic [LENGTH-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  localparam int unsigned SumW  = sum_w(LENGTH);
  localparam cc_mode_e    Mode  = (MODE == "SUM") ? CC_SUM : CC_ACC;
  localparam bit          IsAcc = (Mode == CC_ACC);
  localparam bit          SatOn = (SAT == "TRUE");

  if (ACC_W < SumW || ACC_W > 63) begin : gen_bad_acc_w
    $error("counter_chain_acc: ACC_W must be in LENGTH+3..63");
  end
  if (MODE != "SUM" && MODE != "ACC") begin : gen_bad_mode
    $error("counter_chain_acc: MODE must be SUM or ACC");
  end
  if (SAT != "TRUE" && SAT != "FALSE") begin : gen_bad_sat
    $error("counter_chain_acc: SAT must be TRUE or FALSE");
  end

  logic [SumW-1:0]  comb_sum;
  logic [SumW-1:0]  s1_sum;
  logic             s1_last;
  logic             s1_v;
  logic             s1_go;
  logic [ACC_W-1:0] acc;
  logic             ovf_acc;
  logic [ACC_W-1:0] sum_ext;
  logic [ACC_W-1:0] wrap_sum;
  logic [64:0]      sat_full;
  logic [ACC_W-1:0] add_res;
  logic             add_carry;
  logic             unused_sat;

  cc_sum_stage #(
    .LENGTH (LENGTH),
    .USETNM (USETNM)
  ) u_sum (
    .a0  (a0),
    .a1  (a1),
    .a2  (a2),
    .a3  (a3),
    .b   (b),
    .sum (comb_sum)
  );

  // Non-last ACC beats only touch the accumulator, so they never wait on the output.
  assign s1_go    = s1_v & (~out_valid | out_ready | (IsAcc & ~s1_last));
  assign in_ready = ~s1_v | s1_go;

  assign sum_ext    = ACC_W'(s1_sum);
  assign wrap_sum   = acc + sum_ext;
  assign sat_full   = sat_add(64'(acc), 64'(sum_ext), ACC_W);
  assign add_carry  = sat_full[64];
  // Once saturated, acc is all-ones and any further add saturates again.
  assign add_res    = SatOn ? sat_full[ACC_W-1:0] : wrap_sum;
  assign unused_sat = ^sat_full[63:ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sum    <= '0;
      s1_last   <= 1'b0;
      s1_v      <= 1'b0;
      acc       <= '0;
      ovf_acc   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s1_sum  <= comb_sum;
        s1_last <= in_last;
        s1_v    <= 1'b1;
      end else if (s1_go) begin
        s1_v <= 1'b0;
      end

      // A result loading below in the same cycle overrides this clear.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (s1_go) begin
        if (!IsAcc) begin
          out_data  <= sum_ext;
          out_ovf   <= 1'b0;
          out_valid <= 1'b1;
        end else if (!s1_last) begin
          acc     <= add_res;
          ovf_acc <= ovf_acc | add_carry;
        end else begin
          out_data  <= add_res;
          out_ovf   <= ovf_acc | add_carry;
          acc       <= '0;
          ovf_acc   <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule
